// File: rtl/counter_poll_seq.sv
`default_nettype none
// ============================================================================
//  Module   : counter_poll_seq
//  Purpose  : Sole master of the shared encoder counter bus. Walks oe/sel over
//             NC channels, latches each count into a shadow bank, then commits
//             all channels in one clock. The commit also produces the signed
//             8-bit delta of each channel since the previous snapshot.
//  Ports    : clk       - system clock, rising edge
//             rst       - asynchronous reset, active low
//             start     - one-cycle snapshot request
//             countin   - count bus from counter_top (undriven when oe=0)
//             oe, sel   - output enable / channel select to counter_top
//             busy      - sequence in progress
//             done      - one-cycle pulse, new snapshot visible on rd_*
//             overrun   - sticky: trigger arrived while not idle
//             rd_sel    - snapshot bank read select
//             rd_count  - committed count of channel rd_sel
//             rd_diff   - committed two's-complement delta of channel rd_sel
//  Options  : COUNTER_POLL_TIMER_EN - free-running auto-poll timer (PERIOD)
//  Revision : 1.0 - initial release
// ============================================================================
module counter_poll_seq #(
  parameter int NC     = 4,
  parameter int SETTLE = 1,
  parameter int PERIOD = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] countin,
  output logic       oe,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_count,
  output logic [7:0] rd_diff
);

  localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [1:0]      CH_LAST     = 2'(NC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SAMPLE = 3'd2,
    S_GAP    = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      ch_q, ch_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            overrun_q, overrun_d;
  logic            first_q;
  logic            trig;
  logic            sample_en;
  logic            commit_en;

  // Banks are sized for the full 2-bit select; channels >= NC stay at zero.
  logic [7:0]      shadow_q [4];
  logic [7:0]      count_q  [4];
  logic [7:0]      diff_q   [4];

`ifdef COUNTER_POLL_TIMER_EN
  localparam int            TW          = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TMR_RELOAD  = TW'(PERIOD - 1);

  logic [TW-1:0] tmr_q;
  logic          tick;

  // Free-running: independent of the FSM, so a slow sequence shows up as
  // overrun rather than stretching the poll period.
  assign tick = (tmr_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q <= TMR_RELOAD;
    end else if (tick) begin
      tmr_q <= TMR_RELOAD;
    end else begin
      tmr_q <= tmr_q - 1'b1;
    end
  end

  assign trig = start | tick;
`else
  assign trig = start;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ch_q      <= 2'd0;
      settle_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      settle_q  <= settle_d;
      overrun_q <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    settle_d  = settle_q;
    overrun_d = overrun_q;
    oe        = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    sample_en = 1'b0;
    commit_en = 1'b0;

    // Only IDLE accepts a trigger; COMMIT still counts as occupied.
    if (trig) begin
      overrun_d = (state_q != S_IDLE);
    end

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (trig) begin
          state_d  = S_DRIVE;
          ch_d     = 2'd0;
          settle_d = '0;
        end
      end
      S_DRIVE: begin
        oe = 1'b1;
        if (settle_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        oe        = 1'b1;
        sample_en = 1'b1;
        state_d   = S_GAP;
      end
      S_GAP: begin
        // oe is low here, so the select may move on at the end of this cycle.
        if (ch_q == CH_LAST) begin
          commit_en = 1'b1;
          state_d   = S_COMMIT;
        end else begin
          ch_d     = ch_q + 2'd1;
          settle_d = '0;
          state_d  = S_DRIVE;
        end
      end
      S_COMMIT: begin
        busy    = 1'b0;
        done    = 1'b1;
        ch_d    = 2'd0;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign sel     = ch_q;
  assign overrun = overrun_q;

  // --------------------------------------------------------------------------
  // Shadow / committed banks. The commit edge is the one entering COMMIT so
  // that the new snapshot is already visible while done is high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= 8'd0;
        count_q[i]  <= 8'd0;
        diff_q[i]   <= 8'd0;
      end
      first_q <= 1'b1;
    end else begin
      if (sample_en) begin
        shadow_q[ch_q] <= countin;
      end
      if (commit_en) begin
        for (int i = 0; i < NC; i++) begin
          count_q[i] <= shadow_q[i];
          // Modulo-256 subtraction gives the correct signed delta across
          // counter wrap as long as |speed| < 128 counts per snapshot.
          diff_q[i]  <= first_q ? 8'd0 : (shadow_q[i] - count_q[i]);
        end
        first_q <= 1'b0;
      end
    end
  end

  assign rd_count = count_q[rd_sel];
  assign rd_diff  = diff_q[rd_sel];

endmodule
`default_nettype wire

// File: tb/tb_counter_poll_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_poll_seq
//  Purpose  : Self-checking bench for counter_poll_seq with a counter_top bus
//             model and a snapshot/delta reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_poll_seq;

  localparam int NC     = 4;
  localparam int SETTLE = 1;
`ifdef COUNTER_POLL_TIMER_EN
  localparam int PERIOD = 20;
`else
  localparam int PERIOD = 2000;
`endif
  localparam int LAT    = NC * (SETTLE + 2) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  wire  [7:0] countin;
  logic       oe;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic       overrun;
  logic [1:0] rd_sel;
  logic [7:0] rd_count;
  logic [7:0] rd_diff;

  always #5 clk = ~clk;

  counter_poll_seq #(
    .NC     (NC),
    .SETTLE (SETTLE),
    .PERIOD (PERIOD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .countin  (countin),
    .oe       (oe),
    .sel      (sel),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun),
    .rd_sel   (rd_sel),
    .rd_count (rd_count),
    .rd_diff  (rd_diff)
  );

  // counter_top model: drives the selected channel only while enabled
  logic [7:0] chan_val [4];
  assign countin = oe ? chan_val[sel] : 8'bz;

  int checks = 0;
  int errors = 0;

  // Reference model: what a reader should see after each snapshot
  logic [7:0] ref_count [4];
  logic [7:0] ref_diff  [4];
  bit         ref_first;

  function automatic void ref_reset();
    for (int i = 0; i < 4; i++) begin
      ref_count[i] = 8'd0;
      ref_diff[i]  = 8'd0;
    end
    ref_first = 1'b1;
  endfunction

  function automatic void ref_snapshot();
    int d;
    for (int i = 0; i < NC; i++) begin
      d = int'(chan_val[i]) - int'(ref_count[i]);
      if (d < 0) d = d + 256;
      ref_diff[i]  = ref_first ? 8'd0 : 8'(d);
      ref_count[i] = chan_val[i];
    end
    ref_first = 1'b0;
  endfunction

  // Per-cycle bus protocol monitor
  logic       prev_oe  = 1'b0;
  logic [1:0] prev_sel = 2'd0;
  logic       prev_rst = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst === 1'b1 && prev_rst === 1'b1) begin
      if (sel !== prev_sel) begin
        checks++;
        if (prev_oe !== 1'b0) begin
          errors++;
          $display("FAIL sel_change_oe: sel %0d->%0d with oe=%b, required oe=0",
                   prev_sel, sel, prev_oe);
        end
      end
      if (oe === 1'b1) begin
        checks++;
        if (countin !== chan_val[sel]) begin
          errors++;
          $display("FAIL bus_value: countin=%h, required %h (sel %0d)",
                   countin, chan_val[sel], sel);
        end
      end
    end
    prev_oe  = oe;
    prev_sel = sel;
    prev_rst = rst;
  end

  task automatic check_bank(input string name);
    for (int c = 0; c < 4; c++) begin
      rd_sel = 2'(c);
      #1;
      checks++;
      if (rd_count !== ref_count[c]) begin
        errors++;
        $display("FAIL %s_count[%0d]: got %h, required %h", name, c, rd_count, ref_count[c]);
      end
      checks++;
      if (rd_diff !== ref_diff[c]) begin
        errors++;
        $display("FAIL %s_diff[%0d]: got %h, required %h", name, c, rd_diff, ref_diff[c]);
      end
    end
  endtask

  // Issues a start (caller is at posedge+1) and runs to the done cycle.
  // pulse_at: cycle number at which an extra start is raised (0 = none).
  task automatic do_snapshot(input string name, input int pulse_at, output int lat);
    bit   done_seen;
    bit   last_oe;
    int   n_rise;
    done_seen = 1'b0;
    last_oe   = 1'b0;
    n_rise    = 0;
    lat       = 0;
    start     = 1'b1;
    while (lat < 60 && !done_seen) begin
      @(posedge clk);
      #1;
      lat++;
      start = (lat == pulse_at);
      if (oe === 1'b1 && !last_oe) begin
        checks++;
        if (sel !== 2'(n_rise)) begin
          errors++;
          $display("FAIL %s_sel_order: got sel %0d, required %0d", name, sel, n_rise);
        end
        n_rise++;
      end
      last_oe = (oe === 1'b1);
      if (done === 1'b1) begin
        done_seen = 1'b1;
      end else begin
        rd_sel = 2'(lat % 4);
        #1;
        checks++;
        if (rd_count !== ref_count[lat % 4]) begin
          errors++;
          $display("FAIL %s_early_update: rd_count %h, required old %h", name,
                   rd_count, ref_count[lat % 4]);
        end
      end
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s_timeout: no done within 60 cycles, required %0d", name, LAT);
      start = 1'b0;
    end else begin
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("FAIL %s_latency: got %0d, required %0d", name, lat, LAT);
      end
      checks++;
      if (busy !== 1'b0 || oe !== 1'b0) begin
        errors++;
        $display("FAIL %s_done_cycle: busy=%b oe=%b, required 0 0", name, busy, oe);
      end
      checks++;
      if (n_rise != NC) begin
        errors++;
        $display("FAIL %s_channels: got %0d, required %0d", name, n_rise, NC);
      end
      ref_snapshot();
      check_bank(name);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    start  = 1'b0;
    rd_sel = 2'd0;
    for (int i = 0; i < 4; i++) chan_val[i] = 8'd0;
    ref_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({oe, sel, busy, done, overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: oe,sel,busy,done,overrun=%b, required 000000",
               {oe, sel, busy, done, overrun});
    end
    check_bank("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_snapshot();
    int lat;
    chan_val[0] = 8'd10; chan_val[1] = 8'd20; chan_val[2] = 8'd30; chan_val[3] = 8'd40;
    do_snapshot("first", 0, lat);
  endtask

  task automatic test_second_snapshot();
    int         lat;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h05; exp_d[1] = 8'hFE; exp_d[2] = 8'h00; exp_d[3] = 8'hA0;
    repeat (2) @(posedge clk);
    #1;
    chan_val[0] = 8'd15; chan_val[1] = 8'd18; chan_val[2] = 8'd30; chan_val[3] = 8'd200;
    do_snapshot("second", 0, lat);
    for (int c = 0; c < 4; c++) begin
      rd_sel = 2'(c);
      #0.5;
      checks++;
      if (rd_diff !== exp_d[c]) begin
        errors++;
        $display("FAIL second_const_diff[%0d]: got %h, required %h", c, rd_diff, exp_d[c]);
      end
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [7:0] pat [3];
    logic [7:0] want [3];
    pat[0] = 8'hFE; pat[1] = 8'h03; pat[2] = 8'hFE;
    want[1] = 8'h05; want[2] = 8'hFB;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chan_val[0] = pat[k];
      do_snapshot("wrap", 0, lat);
      if (k > 0) begin
        rd_sel = 2'd0;
        #0.5;
        checks++;
        if (rd_diff !== want[k]) begin
          errors++;
          $display("FAIL wrap_diff0: got %h, required %h", rd_diff, want[k]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int lat;
    @(posedge clk);
    #1;
    chan_val[1] = 8'h55;
    do_snapshot("overrun", 4, lat);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    @(posedge clk);
    #1;
    chan_val[2] = 8'h77;
    do_snapshot("ovr_clear", 0, lat);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b, required 0", overrun);
    end
  endtask

  task automatic test_commit_start();
    int lat;
    @(posedge clk);
    #1;
    do_snapshot("commit_start", LAT, lat);
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL commit_start: overrun=%b busy=%b, required 1 0", overrun, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || oe !== 1'b0) begin
      errors++;
      $display("FAIL commit_start_idle: busy=%b oe=%b, required 0 0", busy, oe);
    end
  endtask

  task automatic test_random();
    int lat;
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) chan_val[i] = 8'($urandom);
      do_snapshot("random", 0, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chan_val[i] = 8'($urandom);
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    checks++;
    if (oe !== 1'b1 || sel !== 2'd2) begin
      errors++;
      $display("FAIL mid_position: oe=%b sel=%0d, required 1 2", oe, sel);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: oe=%b busy=%b done=%b, required 0 0 0", oe, busy, done);
    end
    ref_reset();
    check_bank("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_snapshot("post_reset", 0, lat);
  endtask

`ifdef COUNTER_POLL_TIMER_EN
  task automatic test_timer();
    int cyc;
    int last;
    int pulses;
    cyc    = 0;
    last   = -1;
    pulses = 0;
    while (cyc < 200 && pulses < 4) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != PERIOD) begin
            errors++;
            $display("FAIL timer_period: got %0d, required %0d", cyc - last, PERIOD);
          end
        end
        last = cyc;
        pulses++;
      end
    end
    checks++;
    if (pulses < 4) begin
      errors++;
      $display("FAIL timer_pulses: got %0d, required 4", pulses);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL timer_overrun: got %b, required 0", overrun);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef COUNTER_POLL_TIMER_EN
    test_timer();
`else
    test_first_snapshot();
    test_second_snapshot();
    test_wrap();
    test_overrun();
    test_commit_start();
    test_random();
    test_reset_mid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
